// File: rtl/avl_resp_pkg.sv
// Shared types and constants for the Avalon-MM memory responder.
package avl_resp_pkg;

   // Responder lifecycle: counting out the init delay, then serving commands.
   typedef enum logic {ST_INIT, ST_RUN} st_e;

   // Backpressure LFSR seed and Fibonacci tap mask (taps 16,14,13,11 -> bits 15,13,12,10).
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // One LFSR step: shift left, feedback is the parity of the tapped bits.
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[14:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/avl_mem_responder_if.sv
// Avalon-MM bus between the test master and the memory responder.
// Handshake: a command (exactly one of avl_read/avl_write) is taken on the rising
// edge where avl_waitrequest_n=1; the master holds it steady until then. Read data
// comes back in order as one-cycle avl_readdatavalid strobes.
interface avl_mem_responder_if #(
   parameter int ADDR_W = 24,
   parameter int DATA_W = 512,
   parameter int BE_W   = DATA_W / 8
);
   logic              avl_waitrequest_n;
   logic [ADDR_W-1:0] avl_address;
   logic              avl_read;
   logic              avl_write;
   logic              avl_burstbegin;
   logic [2:0]        avl_burstcount;
   logic [BE_W-1:0]   avl_byteenable;
   logic [DATA_W-1:0] avl_writedata;
   logic [DATA_W-1:0] avl_readdata;
   logic              avl_readdatavalid;

   modport master (
      input  avl_waitrequest_n, avl_readdata, avl_readdatavalid,
      output avl_address, avl_read, avl_write, avl_burstbegin,
             avl_burstcount, avl_byteenable, avl_writedata
   );

   modport slave (
      output avl_waitrequest_n, avl_readdata, avl_readdatavalid,
      input  avl_address, avl_read, avl_write, avl_burstbegin,
             avl_burstcount, avl_byteenable, avl_writedata
   );
endinterface

// File: rtl/avl_resp_lfsr.sv
// Free-running 16-bit Fibonacci LFSR with enable; drives pseudo-random backpressure.
module avl_resp_lfsr
   import avl_resp_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   output logic [15:0] lfsr
);

   // Advance one step per enabled cycle; reseed on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  lfsr <= LFSR_SEED;
      else if (en) lfsr <= lfsr_next(lfsr);
   end

endmodule

// File: rtl/avl_mem_responder.sv
// Avalon-MM responder standing in for the DDR3 controller user interface:
// init delay, waitrequest with an outstanding-read cap, fixed-latency in-order
// read return, on-chip byte-writable RAM. Define AVL_RESP_STALL_EN to add
// LFSR-driven pseudo-random backpressure on avl_waitrequest_n.
module avl_mem_responder
   import avl_resp_pkg::*;
#(
   parameter int ADDR_W          = 24,
   parameter int DATA_W          = 512,
   parameter int BE_W            = DATA_W / 8,
   parameter int MEM_AW          = 10,
   parameter int RD_LAT          = 4,
   parameter int MAX_OUTSTANDING = 8,
   parameter int INIT_CYCLES     = 256
) (
   input  logic                iCLK,
   input  logic                iRST_n,
   avl_mem_responder_if.slave  avl,
   output logic                local_init_done,
   output logic                resp_err,
   output st_e                 dbg_state
);

   localparam int CNT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
   localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

   st_e              state, state_nxt;
   logic [CNT_W-1:0] init_cnt, init_cnt_nxt;
   logic [OUT_W-1:0] outstanding;
   logic             stall_ok;
   logic             acc_rd, acc_wr, err_both, err_burst;
   logic [MEM_AW-1:0] idx;
   logic [RD_LAT-1:0] vld;
   logic              head_vld;
   logic [DATA_W-1:0] rd_q, head_data;
   logic [DATA_W-1:0] mem [0:(1<<MEM_AW)-1];
   logic              unused_ok;

   assign unused_ok = ^{avl.avl_burstbegin, avl.avl_address[ADDR_W-1:MEM_AW]};

   // State and init-counter registers.
   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         state    <= ST_INIT;
         init_cnt <= '0;
      end else begin
         state    <= state_nxt;
         init_cnt <= init_cnt_nxt;
      end
   end

   // Next state: count out INIT_CYCLES, then stay in RUN until reset.
   always_comb begin
      state_nxt    = state;
      init_cnt_nxt = init_cnt;
      case (state)
         ST_INIT: begin
            if (init_cnt == CNT_W'(INIT_CYCLES - 1)) state_nxt = ST_RUN;
            else                                     init_cnt_nxt = init_cnt + CNT_W'(1);
         end
         ST_RUN:  state_nxt = ST_RUN;
         default: state_nxt = ST_INIT;
      endcase
   end

   assign local_init_done = (state == ST_RUN);
   assign dbg_state       = state;

`ifdef AVL_RESP_STALL_EN
   logic [15:0] lfsr;
   logic        unused_lfsr;
   avl_resp_lfsr u_lfsr (
      .clk   (iCLK),
      .rst_n (iRST_n),
      .en    (state == ST_RUN),
      .lfsr  (lfsr)
   );
   assign stall_ok    = lfsr[0];
   assign unused_lfsr = ^lfsr[15:1];
`else
   assign stall_ok = 1'b1;
`endif

   assign avl.avl_waitrequest_n = (state == ST_RUN) &&
                                  (outstanding < OUT_W'(MAX_OUTSTANDING)) && stall_ok;

   assign acc_rd    = avl.avl_waitrequest_n && avl.avl_read && !avl.avl_write;
   assign acc_wr    = avl.avl_waitrequest_n && avl.avl_write && !avl.avl_read;
   assign err_both  = avl.avl_waitrequest_n && avl.avl_read && avl.avl_write;
   assign err_burst = (acc_rd || acc_wr) && (avl.avl_burstcount != 3'd1);
   assign idx       = avl.avl_address[MEM_AW-1:0];

   // Simple dual-port RAM: byte-masked write, registered read on accept.
   always_ff @(posedge iCLK) begin
      if (acc_wr) begin
         for (int i = 0; i < BE_W; i++)
            if (avl.avl_byteenable[i]) mem[idx][8*i +: 8] <= avl.avl_writedata[8*i +: 8];
      end
      if (acc_rd) rd_q <= mem[idx];
   end

   // Read-valid shift pipeline; stage 0 lines up with the RAM output register.
   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) vld <= '0;
      else         vld <= (vld << 1) | RD_LAT'(acc_rd);
   end
   assign head_vld = vld[RD_LAT-1];

   generate
      if (RD_LAT == 1) begin : g_lat1
         assign head_data = rd_q;
      end else begin : g_latn
         logic [DATA_W-1:0] dly [1:RD_LAT-1];
         // Data delay line trailing the RAM output register.
         always_ff @(posedge iCLK) begin
            dly[1] <= rd_q;
            for (int i = 2; i < RD_LAT; i++) dly[i] <= dly[i-1];
         end
         assign head_data = dly[RD_LAT-1];
      end
   endgenerate

   // Return strobe/data, outstanding-read count and sticky error flag.
   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         avl.avl_readdatavalid <= 1'b0;
         avl.avl_readdata      <= '0;
         outstanding           <= '0;
         resp_err              <= 1'b0;
      end else begin
         avl.avl_readdatavalid <= head_vld;
         if (head_vld) avl.avl_readdata <= head_data;
         case ({acc_rd, head_vld})
            2'b10:   outstanding <= outstanding + OUT_W'(1);
            2'b01:   outstanding <= outstanding - OUT_W'(1);
            default: outstanding <= outstanding;
         endcase
         if (err_both || err_burst) resp_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_avl_mem_responder.sv
// Bench for avl_mem_responder: directed and random Avalon traffic checked
// against a word-array memory model and an in-order expected-return queue.
module tb_avl_mem_responder;
   import avl_resp_pkg::*;

   localparam int ADDR_W = 24, DATA_W = 512, BE_W = 64, MEM_AW = 10;
   localparam int RD_LAT = 4, MAX_OUT = 2, INIT_CYCLES = 256;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic local_init_done, resp_err;
   st_e  dbg_state;

   avl_mem_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) avl_bus ();

   avl_mem_responder #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_AW(MEM_AW), .RD_LAT(RD_LAT),
      .MAX_OUTSTANDING(MAX_OUT), .INIT_CYCLES(INIT_CYCLES)
   ) dut (
      .iCLK(clk), .iRST_n(rst_n), .avl(avl_bus),
      .local_init_done(local_init_done), .resp_err(resp_err), .dbg_state(dbg_state)
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc++;

   int checks = 0, failures = 0, rdv_seen = 0;
   logic [DATA_W-1:0] exp_q[$];
   int                exp_cyc_q[$];
   int                tgt_hist[$];
   int                acc_edges[$];
   logic [DATA_W-1:0] ref_mem [1<<MEM_AW];
   bit                written [1<<MEM_AW];
   logic [DATA_W-1:0] mon_d;
   int                mon_t;

   function automatic void chk(string name, logic [DATA_W-1:0] act, logic [DATA_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic logic [DATA_W-1:0] rand_data();
      logic [DATA_W-1:0] r;
      for (int i = 0; i < DATA_W/32; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   // reference model: memory word update with byte mask
   function automatic void model_wr(logic [ADDR_W-1:0] a, logic [BE_W-1:0] be, logic [DATA_W-1:0] d);
      int w;
      w = int'(a[MEM_AW-1:0]);
      for (int i = 0; i < BE_W; i++)
         if (be[i]) ref_mem[w][8*i +: 8] = d[8*i +: 8];
      written[w] = 1'b1;
   endfunction

   // called at the negedge before the accepting edge (edge cyc+1)
   function automatic void push_read(logic [ADDR_W-1:0] a);
      int n, k;
      n = 0;
      k = cyc + 1;
      foreach (tgt_hist[j]) if (tgt_hist[j] > cyc) n++;
      chk("outstanding_cap", (n < MAX_OUT), 1'b1);
      exp_q.push_back(ref_mem[int'(a[MEM_AW-1:0])]);
      exp_cyc_q.push_back(k + RD_LAT);
      tgt_hist.push_back(k + RD_LAT);
   endfunction

   // monitor: every readdatavalid must match the head of the expected queue
   always @(negedge clk) begin
      if (avl_bus.avl_readdatavalid) begin
         rdv_seen++;
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_rdv: got readdatavalid=1 at cycle %0d required 0", cyc);
         end else begin
            mon_d = exp_q.pop_front();
            mon_t = exp_cyc_q.pop_front();
            chk("rd_data", avl_bus.avl_readdata, mon_d);
            chk("rd_latency", cyc, mon_t);
         end
      end
   end

   task automatic idle();
      avl_bus.avl_read       = 1'b0;
      avl_bus.avl_write      = 1'b0;
      avl_bus.avl_burstbegin = 1'b0;
      avl_bus.avl_burstcount = 3'd1;
      avl_bus.avl_address    = '0;
      avl_bus.avl_byteenable = '0;
      avl_bus.avl_writedata  = '0;
   endtask

   // driver: present one command, hold until accepted; ends at posedge+1
   task automatic cmd(input bit rd, input bit wr, input logic [ADDR_W-1:0] a,
                      input logic [BE_W-1:0] be, input logic [DATA_W-1:0] d, input logic [2:0] bc);
      bit ok = 1'b0;
      avl_bus.avl_read = rd;  avl_bus.avl_write = wr;  avl_bus.avl_address = a;
      avl_bus.avl_byteenable = be;  avl_bus.avl_writedata = d;  avl_bus.avl_burstcount = bc;
      avl_bus.avl_burstbegin = 1'b1;
      for (int g = 0; g < 200 && !ok; g++) begin
         @(negedge clk);
         if (avl_bus.avl_waitrequest_n) begin
            ok = 1'b1;
            if (rd && !wr) push_read(a);
            if (wr && !rd) model_wr(a, be, d);
         end
         @(posedge clk);
         #1;
      end
      idle();
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL cmd_timeout: got no accept in 200 cycles required accept");
      end
   endtask

   // read held high, address advancing after each accept
   task automatic rd_stream(input int n, input logic [ADDR_W-1:0] base);
      int got = 0;
      acc_edges.delete();
      avl_bus.avl_read = 1'b1;  avl_bus.avl_burstcount = 3'd1;  avl_bus.avl_address = base;
      for (int g = 0; g < 300 && got < n; g++) begin
         @(negedge clk);
         if (avl_bus.avl_waitrequest_n) begin
            acc_edges.push_back(cyc + 1);
            push_read(avl_bus.avl_address);
            got++;
         end
         @(posedge clk);
         #1;
         avl_bus.avl_address = base + ADDR_W'(got);
      end
      idle();
      chk("stream_accepts", got, n);
   endtask

   task automatic drain();
      for (int g = 0; g < 100 && exp_q.size() != 0; g++) @(posedge clk);
      #1;
      chk("drain", exp_q.size(), 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      exp_q.delete();  exp_cyc_q.delete();  tgt_hist.delete();
      idle();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_init_done", local_init_done, 1'b0);
      chk("rst_waitreq_n", avl_bus.avl_waitrequest_n, 1'b0);
      chk("rst_rdv", avl_bus.avl_readdatavalid, 1'b0);
      chk("rst_rdata", avl_bus.avl_readdata, '0);
      chk("rst_err", resp_err, 1'b0);
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic wait_init();
      bit ok = 1'b0;
      for (int g = 0; g < INIT_CYCLES + 50 && !ok; g++) begin
         @(negedge clk);
         ok = local_init_done;
      end
      chk("init_done_seen", ok, 1'b1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish by 2ms required finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic [DATA_W-1:0] pat, ones, dx, dy, dz;
      logic [ADDR_W-1:0] a;
      logic [BE_W-1:0]   be;
      int early, rdv0, w;

      idle();
      do_reset();
      // init timing: done rises at the INIT_CYCLES-th edge after release
      early = 0;
      for (int i = 1; i <= INIT_CYCLES; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (i < INIT_CYCLES && (avl_bus.avl_waitrequest_n || local_init_done)) early++;
         if (i == INIT_CYCLES - 1) chk("init_before", local_init_done, 1'b0);
         if (i == INIT_CYCLES) begin
            chk("init_at", local_init_done, 1'b1);
            chk("ready_at", avl_bus.avl_waitrequest_n, 1'b1);
         end
      end
      chk("no_early_ready", early, 0);
      @(posedge clk);
      #1;

      // write/readback and aliasing
      pat  = {64{8'hA5}};
      ones = {64{8'hFF}};
      cmd(0, 1, 24'd3, ones[BE_W-1:0], pat, 3'd1);
      cmd(1, 0, 24'd3, '0, '0, 3'd1);
      cmd(1, 0, 24'd3 + 24'd1024, '0, '0, 3'd1);
      // byte enables
      cmd(0, 1, 24'd7, ones[BE_W-1:0], ones, 3'd1);
      cmd(0, 1, 24'd7, 64'h1, '0, 3'd1);
      cmd(1, 0, 24'd7, '0, '0, 3'd1);
      drain();

      // random traffic with upper address bits set
      for (int n = 0; n < 40; n++) begin
         w = 100 + $urandom_range(0, 15);
         a = ADDR_W'($urandom);
         a[MEM_AW-1:0] = MEM_AW'(w);
         if (!written[w] || $urandom_range(0, 1) == 1) begin
            be = written[w] ? {$urandom, $urandom} : ones[BE_W-1:0];
            cmd(0, 1, a, be, rand_data(), 3'd1);
         end else begin
            cmd(1, 0, a, '0, '0, 3'd1);
         end
      end
      drain();

      // outstanding limit
      for (int i = 0; i < 6; i++) cmd(0, 1, ADDR_W'(40 + i), ones[BE_W-1:0], rand_data(), 3'd1);
      rd_stream(6, 24'd40);
      chk("limit_pair", acc_edges[1] - acc_edges[0], 1);
      chk("limit_reopen", acc_edges[2] - acc_edges[0], RD_LAT + 1);
      drain();
      chk("err_clean", resp_err, 1'b0);

      // burstcount != 1: executed as a single beat, error flagged
      dx = rand_data();
      dy = rand_data();
      cmd(0, 1, 24'd21, ones[BE_W-1:0], dy, 3'd1);
      cmd(0, 1, 24'd20, ones[BE_W-1:0], dx, 3'd2);
      chk("err_burst", resp_err, 1'b1);
      cmd(1, 0, 24'd20, '0, '0, 3'd1);
      cmd(1, 0, 24'd21, '0, '0, 3'd1);
      drain();

      // read+write together: consumed, no RAM access, no return
      do_reset();
      wait_init();
      chk("err_cleared", resp_err, 1'b0);
      rdv0 = rdv_seen;
      cmd(1, 1, 24'd3, ones[BE_W-1:0], rand_data(), 3'd1);
      chk("err_both", resp_err, 1'b1);
      repeat (10) @(posedge clk);
      #1;
      chk("both_no_rdv", rdv_seen, rdv0);
      cmd(1, 0, 24'd3, '0, '0, 3'd1);
      drain();

      // reset with reads in flight
      dz = rand_data();
      cmd(0, 1, 24'd30, ones[BE_W-1:0], dz, 3'd1);
      rd_stream(2, 24'd40);
      do_reset();
      rdv0 = rdv_seen;
      wait_init();
      chk("reset_drop_rdv", rdv_seen, rdv0);
      cmd(1, 0, 24'd30, '0, '0, 3'd1);
      cmd(1, 0, 24'd41, '0, '0, 3'd1);
      cmd(1, 0, 24'd3, '0, '0, 3'd1);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
